// File: rtl/fsize_buffer_read_arbiter.sv
// ----------------------------------------------------------------------------
// fsize_buffer_read_arbiter
//
// Shares the single read port of an FSIZE-wide buffer RAM among NUM_REQ
// requesters with round-robin arbitration. The single write stream passes
// through to the RAM write port after one register stage. Each issued read
// carries its requester ID down a tag pipeline that matches the RAM read
// latency, so the response comes back with a one-hot per-requester valid.
// A read that would hit a write still in flight is held back.
//
// Ports:
//   clk        clock
//   rst        asynchronous active-high reset
//   req_valid  [NUM_REQ]          read request per requester
//   req_addr   [NUM_REQ*ADDR_W]   read address, slice i belongs to requester i
//   req_ready  [NUM_REQ]          one-hot grant (combinational)
//   wr_en      write request, always accepted
//   wr_addr    [ADDR_W]           write address
//   wr_data    [FSIZE]            write data
//   ram_raddr  [ADDR_W]           RAM read address (registered)
//   ram_waddr  [ADDR_W]           RAM write address (registered)
//   ram_wdata  [FSIZE]            RAM write data (registered)
//   ram_wren   RAM write enable (registered)
//   ram_rdata  [FSIZE]            RAM read data
//   rsp_valid  [NUM_REQ]          one-hot response strobe
//   rsp_data   [FSIZE]            response data (RAM read data)
// ----------------------------------------------------------------------------
module fsize_buffer_read_arbiter #(
  parameter int NUM_REQ             = 4,
  parameter int DEPTH               = 512,
  parameter int ADDR_W              = $clog2(DEPTH),
  parameter int FSIZE               = 16,
  parameter int BUFFER_READ_LATENCY = 2,
  parameter int READ_LATENCY        = BUFFER_READ_LATENCY
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      wr_en,
  input  logic [ADDR_W-1:0]         wr_addr,
  input  logic [FSIZE-1:0]          wr_data,
  output logic [ADDR_W-1:0]         ram_raddr,
  output logic [ADDR_W-1:0]         ram_waddr,
  output logic [FSIZE-1:0]          ram_wdata,
  output logic                      ram_wren,
  input  logic [FSIZE-1:0]          ram_rdata,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [FSIZE-1:0]          rsp_data
);

  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [ID_W-1:0]    ptr;
  logic [NUM_REQ-1:0] eligible;
  logic               grant_any;
  logic [ID_W-1:0]    grant_id;
  logic [ADDR_W-1:0]  grant_addr;

  // Tag stages 0..READ_LATENCY-1; rsp_valid itself acts as the final stage,
  // so an accept shows up on rsp_valid 1+READ_LATENCY cycles later.
  logic               tag_valid [0:READ_LATENCY-1];
  logic [ID_W-1:0]    tag_id    [0:READ_LATENCY-1];

  // A requester is blocked while its address matches a write that has not
  // yet reached the RAM: either the one arriving now or the one registered.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible[i] = req_valid[i]
                 && !(wr_en    && (req_addr[i*ADDR_W +: ADDR_W] == wr_addr))
                 && !(ram_wren && (req_addr[i*ADDR_W +: ADDR_W] == ram_waddr));
    end
  end

  // Round-robin search starting at ptr, wrapping around.
  always_comb begin
    int idx;
    idx       = 0;
    grant_any = 1'b0;
    grant_id  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!grant_any && eligible[idx]) begin
        grant_any = 1'b1;
        grant_id  = ID_W'(idx);
      end
    end
    // Nothing may be granted while reset is held.
    if (rst) grant_any = 1'b0;
  end

  assign req_ready  = grant_any ? (NUM_REQ'(1) << grant_id) : '0;
  assign grant_addr = req_addr[grant_id*ADDR_W +: ADDR_W];
  assign rsp_data   = (|rsp_valid) ? ram_rdata : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr       <= '0;
      ram_raddr <= '0;
      ram_waddr <= '0;
      ram_wdata <= '0;
      ram_wren  <= 1'b0;
      rsp_valid <= '0;
      for (int s = 0; s < READ_LATENCY; s++) begin
        tag_valid[s] <= 1'b0;
        tag_id[s]    <= '0;
      end
    end else begin
      ram_wren  <= wr_en;
      ram_waddr <= wr_addr;
      ram_wdata <= wr_data;

      if (grant_any) begin
        ram_raddr <= grant_addr;
        ptr       <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : ID_W'(grant_id + 1'b1);
      end

      tag_valid[0] <= grant_any;
      tag_id[0]    <= grant_id;
      for (int s = 1; s < READ_LATENCY; s++) begin
        tag_valid[s] <= tag_valid[s-1];
        tag_id[s]    <= tag_id[s-1];
      end

      rsp_valid <= tag_valid[READ_LATENCY-1]
                 ? (NUM_REQ'(1) << tag_id[READ_LATENCY-1]) : '0;
    end
  end

endmodule

// File: tb/tb_fsize_buffer_read_arbiter.sv
module tb_fsize_buffer_read_arbiter;

  localparam int NR   = 4;
  localparam int AW   = 9;
  localparam int FW   = 16;
  localparam int RL_A = 1;
  localparam int RL_B = 4;

  logic          clk;
  logic          rst;
  logic [NR-1:0] req_valid;
  logic [NR*AW-1:0] req_addr;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [FW-1:0] wr_data;

  logic [NR-1:0] rdy_a, rv_a, rdy_b, rv_b;
  logic [AW-1:0] raddr_a, waddr_a, raddr_b, waddr_b;
  logic [FW-1:0] wdata_a, rdata_a, rd_a, wdata_b, rdata_b, rd_b;
  logic          wren_a, wren_b;

  int n_cmp = 0;
  int n_err = 0;

  fsize_buffer_read_arbiter #(.NUM_REQ(NR), .DEPTH(512), .ADDR_W(AW), .FSIZE(FW),
                              .READ_LATENCY(RL_A)) dut_a (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(rdy_a), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .ram_raddr(raddr_a), .ram_waddr(waddr_a), .ram_wdata(wdata_a),
    .ram_wren(wren_a), .ram_rdata(rdata_a), .rsp_valid(rv_a), .rsp_data(rd_a));

  fsize_buffer_read_arbiter #(.NUM_REQ(NR), .DEPTH(512), .ADDR_W(AW), .FSIZE(FW),
                              .READ_LATENCY(RL_B)) dut_b (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(rdy_b), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .ram_raddr(raddr_b), .ram_waddr(waddr_b), .ram_wdata(wdata_b),
    .ram_wren(wren_b), .ram_rdata(rdata_b), .rsp_valid(rv_b), .rsp_data(rd_b));

  // Behavioural RAMs with fixed read latency.
  logic [FW-1:0] mem_a [512];
  logic [FW-1:0] mem_b [512];
  logic [FW-1:0] pipe_a [RL_A];
  logic [FW-1:0] pipe_b [RL_B];

  always @(posedge clk) begin
    if (wren_a) mem_a[waddr_a] <= wdata_a;
    pipe_a[0] <= mem_a[raddr_a];
    for (int i = 1; i < RL_A; i++) pipe_a[i] <= pipe_a[i-1];
  end
  always @(posedge clk) begin
    if (wren_b) mem_b[waddr_b] <= wdata_b;
    pipe_b[0] <= mem_b[raddr_b];
    for (int i = 1; i < RL_B; i++) pipe_b[i] <= pipe_b[i-1];
  end
  assign rdata_a = pipe_a[RL_A-1];
  assign rdata_b = pipe_b[RL_B-1];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_addr(input int i, input logic [AW-1:0] a);
    req_addr[i*AW +: AW] = a;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [NR-1:0] exp_v;
    int j;

    rst = 1'b1;
    req_valid = '0;
    req_addr = '0;
    wr_en = 1'b0;
    wr_addr = '0;
    wr_data = '0;

    // Reset state, with requests present to show grants are suppressed.
    req_valid = 4'hF;
    #2;
    chk("reset_ready", rdy_a, 0);
    chk("reset_raddr", raddr_a, 0);
    chk("reset_wren", wren_a, 0);
    chk("reset_rsp", rv_a, 0);
    tick();
    tick();
    req_valid = '0;
    rst = 1'b0;

    // Single read by requester 2 after a write with a 3-cycle gap.
    wr_en = 1'b1; wr_addr = 9'h010; wr_data = 16'h00A5;
    tick();
    wr_en = 1'b0;
    settle();
    chk("wr_wren", wren_a, 1);
    chk("wr_waddr", waddr_a, 9'h010);
    chk("wr_wdata", wdata_a, 16'h00A5);
    tick();
    settle();
    chk("wr_wren_drop", wren_a, 0);
    tick();
    tick();
    req_valid = 4'b0100; set_addr(2, 9'h010);
    settle();
    chk("t1_ready_a", rdy_a, 4'b0100);
    chk("t1_ready_b", rdy_b, 4'b0100);
    tick();
    req_valid = '0;
    settle();
    chk("t1_raddr", raddr_a, 9'h010);
    chk("t1_rsp_a_early", rv_a, 0);
    tick();
    chk("t1_rsp_a", rv_a, 4'b0100);
    chk("t1_data_a", rd_a, 16'h00A5);
    chk("t1_rsp_b_early", rv_b, 0);
    tick();
    chk("t1_rsp_a_once", rv_a, 0);
    tick();
    chk("t1_rsp_b_early2", rv_b, 0);
    tick();
    chk("t1_rsp_b", rv_b, 4'b0100);
    chk("t1_data_b", rd_b, 16'h00A5);
    tick();
    chk("t1_rsp_b_once", rv_b, 0);

    // Sustained burst from all four requesters.
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_addr = AW'(i); wr_data = FW'(16'h00B0 + i);
      tick();
    end
    wr_en = 1'b0;
    tick();
    tick();
    do_reset();
    for (int i = 0; i < 4; i++) set_addr(i, AW'(i));
    for (int k = 0; k < 13; k++) begin
      req_valid = (k < 8) ? 4'hF : 4'h0;
      settle();
      if (k < 8) chk($sformatf("burst_ready_%0d", k), rdy_a, 32'(4'b0001 << (k % 4)));
      j = k - 1 - RL_A;
      exp_v = (j >= 0 && j < 8) ? NR'(4'b0001 << (j % 4)) : '0;
      chk($sformatf("burst_rsp_a_%0d", k), rv_a, exp_v);
      if (j >= 0 && j < 8) chk($sformatf("burst_data_a_%0d", k), rd_a, 16'h00B0 + (j % 4));
      j = k - 1 - RL_B;
      exp_v = (j >= 0 && j < 8) ? NR'(4'b0001 << (j % 4)) : '0;
      chk($sformatf("burst_rsp_b_%0d", k), rv_b, exp_v);
      if (j >= 0 && j < 8) chk($sformatf("burst_data_b_%0d", k), rd_b, 16'h00B0 + (j % 4));
      tick();
    end

    // Read-after-write hazard on requester 1.
    wr_en = 1'b1; wr_addr = 9'h020; wr_data = 16'h005A;
    req_valid = 4'b0010; set_addr(1, 9'h020);
    settle();
    chk("raw_stall0", rdy_a, 0);
    tick();
    wr_en = 1'b0;
    settle();
    chk("raw_stall1", rdy_a, 0);
    tick();
    settle();
    chk("raw_grant_a", rdy_a, 4'b0010);
    chk("raw_grant_b", rdy_b, 4'b0010);
    tick();
    req_valid = '0;
    tick();
    chk("raw_rsp_a", rv_a, 4'b0010);
    chk("raw_data_a", rd_a, 16'h005A);
    tick();
    tick();
    tick();
    chk("raw_rsp_b", rv_b, 4'b0010);
    chk("raw_data_b", rd_b, 16'h005A);

    // Same-cycle hazard on requester 0 lets requester 3 through.
    do_reset();
    wr_en = 1'b1; wr_addr = 9'h040; wr_data = 16'h0011;
    req_valid = 4'b1001; set_addr(0, 9'h040); set_addr(3, 9'h030);
    settle();
    chk("haz_grant3", rdy_a, 4'b1000);
    tick();
    wr_en = 1'b0;
    req_valid = 4'b0001;
    settle();
    chk("haz_raddr", raddr_a, 9'h030);
    chk("haz_stall0", rdy_a, 0);
    tick();
    req_valid = 4'b1001;
    settle();
    chk("haz_grant0", rdy_a, 4'b0001);
    tick();
    req_valid = '0;
    for (int k = 0; k < 8; k++) tick();

    // Reset with reads in flight; pointer is 1 here.
    wr_en = 1'b1; wr_addr = 9'h1FF; wr_data = 16'h0077;
    req_valid = 4'b0111;
    set_addr(0, 9'h005); set_addr(1, 9'h006); set_addr(2, 9'h007);
    settle();
    chk("flight_grant1", rdy_a, 4'b0010);
    tick();
    settle();
    chk("flight_grant2", rdy_a, 4'b0100);
    tick();
    settle();
    chk("flight_grant0", rdy_a, 4'b0001);
    tick();
    rst = 1'b1;
    settle();
    chk("rst_ready_a", rdy_a, 0);
    chk("rst_ready_b", rdy_b, 0);
    chk("rst_raddr", raddr_a, 0);
    chk("rst_waddr", waddr_a, 0);
    chk("rst_wdata", wdata_a, 0);
    chk("rst_wren", wren_a, 0);
    chk("rst_rsp_a", rv_a, 0);
    chk("rst_rsp_b", rv_b, 0);
    chk("rst_data_a", rd_a, 0);
    tick();
    req_valid = '0;
    wr_en = 1'b0;
    rst = 1'b0;
    for (int k = 0; k < 2 * RL_B; k++) begin
      settle();
      chk($sformatf("post_rst_a_%0d", k), rv_a, 0);
      chk($sformatf("post_rst_b_%0d", k), rv_b, 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fsize_buffer_read_arbiter.md
Name: fsize_buffer_read_arbiter

Overview:
- Shares the single read port of one FSIZE-wide buffer RAM among NUM_REQ requesters using round-robin arbitration.
- Forwards the single write stream to the RAM's write port through one register stage.
- Tags every issued read with its requester ID through a pipeline that matches the RAM's fixed read latency, and returns data with a per-requester valid.
- Stalls any read that would hit a write still in flight (read-after-write hazard).
- Sits between the scheduling/PE-feed logic and a BufferRAMTFsize-class memory.

Parameters:
- NUM_REQ, 4, number of read requesters (2..8).
- DEPTH, 512, RAM entries.
- ADDR_W, $clog2(DEPTH), address width.
- READ_LATENCY, BUFFER_READ_LATENCY, RAM cycles from ram_raddr to ram_rdata (>=1).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- req_valid  in  NUM_REQ  read request per requester.
- req_addr  in  NUM_REQ*ADDR_W  read address; requester i uses slice i.
- req_ready  out  NUM_REQ  grant; a read is accepted when valid&ready.
- wr_en  in  1  write request; always accepted.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  FSIZE  write data.
- ram_raddr  out  ADDR_W  RAM read address (registered).
- ram_waddr  out  ADDR_W  RAM write address (registered).
- ram_wdata  out  FSIZE  RAM write data (registered).
- ram_wren  out  1  RAM write enable (registered).
- ram_rdata  in  FSIZE  RAM read data.
- rsp_valid  out  NUM_REQ  one-hot response strobe.
- rsp_data  out  FSIZE  response data (=ram_rdata).

Behaviour:
- Reset (asynchronous, active-high): ram_raddr=0, ram_waddr=0, ram_wdata=0, ram_wren=0, req_ready=0, rsp_valid=0. Round-robin pointer=0 (requester 0 has highest priority after reset). Tag pipeline cleared.
- Reset asserted mid-operation discards every in-flight read; no rsp_valid is produced for those reads after reset is released.
- Write path: ram_wren, ram_waddr and ram_wdata are wr_en, wr_addr and wr_data delayed by one cycle. Writes are never stalled.
- Arbitration:
  - req_ready is combinational and at most one-hot.
  - The grant goes to the first eligible requester at or after the pointer, searching upward with wrap-around.
  - Requester i is eligible if req_valid[i]=1 and no hazard applies to it.
  - On an accepted grant to requester i, the pointer moves to (i+1) mod NUM_REQ.
  - If nothing is granted, the pointer holds.
- Hazard: a request with req_addr equal to wr_addr (when wr_en=1), or equal to ram_waddr (when ram_wren=1), is ineligible that cycle. The next eligible requester may be granted in its place.
- Read issue: an accepted request at edge T sets ram_raddr=req_addr at T+1. If no request is accepted, ram_raddr holds its value.
- Tag pipeline:
  - Depth is 1+READ_LATENCY stages, each holding {valid, id}.
  - Stage 0 is loaded with the accept.
  - rsp_valid[id] asserts exactly 1+READ_LATENCY cycles after the accept edge, for one cycle.
  - rsp_data equals ram_rdata whenever any rsp_valid bit is high; otherwise it is don't-care.
- Throughput: one read accepted per cycle, sustained. Responses return in grant order with no gaps other than idle grant cycles.
- Requesters must hold req_addr stable while req_valid=1 and req_ready=0.

Test Plan:
- Reset, then requester 2 alone at addr 0x010 after a prior write of 0xA5 to 0x010 (with a 3-cycle gap) -> req_ready=0b0100 on that cycle; rsp_valid=0b0100 and rsp_data=0xA5 exactly 1+READ_LATENCY cycles later.
- All 4 requesters valid continuously for 8 cycles, addrs 0x00/0x01/0x02/0x03 -> grants 0,1,2,3,0,1,2,3; responses follow the same ID order, one per cycle, with no gaps.
- wr_en=1 to 0x020 with data 0x5A while requester 1 reads 0x020 -> requester 1 is stalled for 2 cycles (write in flight) and granted in the third cycle; its response returns 0x5A.
- Same-cycle hazard on requester 0 while requester 3 reads 0x030 -> requester 3 is granted, then the pointer moves to 0; requester 0 is granted on the next clear cycle.
- Assert rst while 3 reads are in flight -> all outputs are 0 immediately; no rsp_valid occurs in the 2*READ_LATENCY cycles after release.
- Sweep READ_LATENCY=1 and 4 -> the response offset equals 1+READ_LATENCY in both cases.
